// File: rtl/cpu_bus_serializer.sv
// Serializes a parallel CPU read/write onto a PORT_W pin bus as ADDR, CMD, WDATA, WAIT, RDATA beats.
// Latency accept->ack: AB+1+DB+W+1 cycles. The device stalls via pin_ready in WAIT; the CPU holds until cpu_ack.
module cpu_bus_serializer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PORT_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic [PORT_W-1:0] pin_addr,
    output logic              pin_frame,
    output logic              pin_we,
    output logic [PORT_W-1:0] pin_dout,
    output logic [PORT_W-1:0] pin_oe,
    input  logic [PORT_W-1:0] pin_din,
    input  logic              pin_ready
);

    localparam int AB  = ADDR_W / PORT_W;
    localparam int DB  = DATA_W / PORT_W;
    localparam int MB  = (AB > DB) ? AB : DB;
    localparam int BCW = (MB > 1) ? $clog2(MB) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BCW-1:0] A_LAST = BCW'(AB - 1);
    localparam logic [BCW-1:0] D_LAST = BCW'(DB - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state, state_nxt;
    logic [BCW-1:0]    beat;
    logic [WCW-1:0]    wait_cnt;
    logic              we_q, err_q, timeout_hit;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:  if (cpu_req) state_nxt = S_ADDR;
            S_ADDR:  if (beat == A_LAST) state_nxt = S_CMD;
            S_CMD:   state_nxt = we_q ? S_WDATA : S_WAIT;
            S_WDATA: if (beat == D_LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                // Ready wins over a timeout landing in the same cycle.
                if (pin_ready) begin
                    state_nxt = we_q ? S_DONE : S_RDATA;
                end else if (TIMEOUT > 0 && wait_cnt == W_LAST) begin
                    state_nxt   = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_RDATA: if (beat == D_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            beat     <= '0;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            beat     <= (state_nxt != state) ? '0 : beat + 1'b1;
            wait_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == S_IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (timeout_hit) err_q <= 1'b1;
            if (state == S_RDATA) rdata_q[int'(beat)*PORT_W +: PORT_W] <= pin_din;
        end
    end

    assign cpu_busy  = (state != S_IDLE);
    assign cpu_ack   = (state == S_DONE);
    assign cpu_err   = cpu_ack && err_q;
    assign cpu_rdata = (cpu_ack && !we_q && !err_q) ? rdata_q : '0;
    assign pin_frame = (state != S_IDLE) && (state != S_DONE);
    assign pin_we    = we_q && (state == S_CMD || state == S_WDATA || state == S_WAIT);
    assign pin_addr  = (state == S_ADDR) ? addr_q[int'(beat)*PORT_W +: PORT_W] : '0;
    assign pin_dout  = (state == S_WDATA) ? wdata_q[int'(beat)*PORT_W +: PORT_W] : '0;
    assign pin_oe    = (state == S_WDATA) ? '1 : '0;

endmodule
